ddr_in_gearbox: RTL and testbench
=================================

DDR_IN_GEARBOX -- requirements
Module: ddr_in_gearbox

Interface
REQ-001 Parameter WIDTH, default 16, DDR input bus width in bits (>=1).
REQ-002 Parameter BEATS, default 4, DDR clock cycles assembled per output word (>=2).
REQ-003 Parameter DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-004 clk  input  1  sole clock; rising and falling edges both sample d.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 d  input  WIDTH  DDR data, one value per clk edge.
REQ-007 ce  input  1  capture enable, sampled with the rising-edge data.
REQ-008 clr  input  1  synchronous clear of assembly state, FIFO and overflow.
REQ-009 swap  input  1  pair order: 0 = rise in low half; 1 = fall in low half.
REQ-010 q  output  2*WIDTH*BEATS  FIFO head word.
REQ-011 q_valid  output  1  FIFO non-empty.
REQ-012 q_ready  input  1  consumer accepts q when q_valid is high.
REQ-013 overflow  output  1  sticky: a completed word was dropped.
REQ-014 level  output  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-015 Each bit SHALL be captured on clk rising edge (r) and clk falling edge (f); f SHALL be retimed to the rising domain so that r from posedge n and f from the following negedge form pair n, registered at posedge n+1 together with ce from posedge n.
REQ-016 Pair value SHALL be {f,r} (r in bits [WIDTH-1:0]) when swap=0, and {r,f} when swap=1; swap is sampled with ce.
REQ-017 A registered pair with ce=1 SHALL be written at slice [k*2*WIDTH +: 2*WIDTH] of the assembly register, where k is the beat counter, and k SHALL increment, wrapping BEATS-1 -> 0.
REQ-018 A registered pair with ce=0 SHALL be discarded; k and the assembly register hold.
REQ-019 When the pair at k=BEATS-1 is accepted, the completed word (including that pair) SHALL be pushed into the FIFO on the same edge; q_valid SHALL rise 2 clk cycles after the posedge sampling the final beat's rise data.
REQ-020 Pop SHALL occur on a posedge with q_valid=1 and q_ready=1; q SHALL present the next entry on the following cycle.
REQ-021 Push when full and no simultaneous pop: word dropped, overflow set to 1, k still wraps to 0.
REQ-022 Push and pop on the same edge while full: both SHALL succeed, level unchanged, overflow unchanged.
REQ-023 Push and pop on the same edge while non-full: level unchanged; FIFO order preserved.
REQ-024 q_ready with q_valid=0 SHALL have no effect; level never underflows.
REQ-025 clr=1 at a posedge SHALL zero k, the assembly register, FIFO pointers, level and overflow; the pair registered at that edge SHALL be discarded.
REQ-026 overflow SHALL clear only by clr or rst_n.

Reset
REQ-027 rst_n low SHALL immediately force q_valid=0, level=0, overflow=0, q=0, k=0, and clear all capture, pair and assembly registers and FIFO pointers.
REQ-028 Reset asserted mid-word SHALL discard the partial word; the first pair accepted after release lands at k=0.
REQ-029 Capture SHALL resume at the first posedge after rst_n deassertion; no word is emitted before BEATS accepted pairs.

Structure
REQ-030 A shared package SHALL hold the clog2 function and the swap-mode encodings.
REQ-031 Sub-module ddr_in_lane SHALL implement one bit of dual-edge capture plus negedge-to-posedge retiming, instantiated WIDTH times via generate.
REQ-032 Beat counter, assembly register and FIFO (register array, read/write pointers) SHALL reside in the top module.

Verification (WIDTH=4, BEATS=2, DEPTH=2)
REQ-033 swap=0, ce=1, edges r/f = 1/2, 3/4 -> q=16'h4321, q_valid high 2 cycles after second rise, level=1.
REQ-034 Same data with swap=1 -> q=16'h3412.
REQ-035 ce low on the pair between 1/2 and 3/4 (data 9/9) -> q=16'h4321, 9 never appears.
REQ-036 q_ready=0, three words 16'h1111, 16'h2222, 16'h3333 -> level=2, overflow=1, pops return 1111 then 2222.
REQ-037 FIFO full, third word completes on the same edge as a pop -> overflow stays 0, level stays 2, order 1111, 2222, 3333.
REQ-038 rst_n pulsed low after one beat, then edges 5/6, 7/8 -> q=16'h8765, overflow=0; repeat with clr instead of rst_n -> same result.

Source files
------------

// File: rtl/ddr_in_gearbox_pkg.sv
// rtl/ddr_in_gearbox_pkg.sv - shared encodings and helpers for the DDR input gearbox
package ddr_in_gearbox_pkg;

  typedef enum logic {
    SWAP_RISE_LOW = 1'b0,
    SWAP_FALL_LOW = 1'b1
  } swap_mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/ddr_in_gearbox_if.sv
// rtl/ddr_in_gearbox_if.sv - capture-side and word-stream signals of the DDR input gearbox
interface ddr_in_gearbox_if #(
  parameter int WIDTH = 16,
  parameter int BEATS = 4,
  parameter int DEPTH = 4
);
  import ddr_in_gearbox_pkg::*;

  localparam int WORD_W  = 2 * WIDTH * BEATS;
  localparam int LEVEL_W = clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   d;
  logic               ce;
  logic               clr;
  logic               swap;
  logic [WORD_W-1:0]  q;
  logic               q_valid;
  logic               q_ready;
  logic               overflow;
  logic [LEVEL_W-1:0] level;

  modport master (
    output d, ce, clr, swap, q_ready,
    input  q, q_valid, overflow, level
  );

  modport slave (
    input  d, ce, clr, swap, q_ready,
    output q, q_valid, overflow, level
  );

endinterface

// File: rtl/ddr_in_gearbox_lane.sv
// rtl/ddr_in_gearbox_lane.sv - one bit of dual-edge capture with the fall sample retimed to the rising domain
module ddr_in_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic r_q,
  output logic f_q
);

  logic r_cap;
  logic f_cap;

  // r_q/f_q update together, so the pair (posedge n, following negedge) appears at posedge n+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap <= 1'b0;
      r_q   <= 1'b0;
      f_q   <= 1'b0;
    end else begin
      r_cap <= d;
      r_q   <= r_cap;
      f_q   <= f_cap;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) f_cap <= 1'b0;
    else        f_cap <= d;
  end

endmodule

// File: rtl/ddr_in_gearbox.sv
// rtl/ddr_in_gearbox.sv - assembles BEATS DDR pairs into one word and queues words in a small FIFO
module ddr_in_gearbox
  import ddr_in_gearbox_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BEATS = 4,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  ddr_in_gearbox_if.slave bus
);

  localparam int PAIR_W  = 2 * WIDTH;
  localparam int WORD_W  = PAIR_W * BEATS;
  localparam int KW      = clog2(BEATS);
  localparam int AW      = clog2(DEPTH);
  localparam int LEVEL_W = AW + 1;

  logic [WIDTH-1:0] r_vec;
  logic [WIDTH-1:0] f_vec;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      ddr_in_lane u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.d[i]),
        .r_q   (r_vec[i]),
        .f_q   (f_vec[i])
      );
    end
  endgenerate

  logic       ce_s;
  logic       ce_q;
  swap_mode_e swap_s;
  swap_mode_e swap_q;

  // ce/swap follow the rise data through the same two-stage delay as the lanes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_s   <= 1'b0;
      ce_q   <= 1'b0;
      swap_s <= SWAP_RISE_LOW;
      swap_q <= SWAP_RISE_LOW;
    end else begin
      ce_s   <= bus.ce;
      swap_s <= swap_mode_e'(bus.swap);
      ce_q   <= ce_s & ~bus.clr;
      swap_q <= swap_s;
    end
  end

  logic [PAIR_W-1:0]  pair;
  logic [KW-1:0]      k;
  logic [WORD_W-1:0]  asm_q;
  logic [WORD_W-1:0]  word_next;
  logic [WORD_W-1:0]  mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LEVEL_W-1:0] level_q;
  logic               ovf_q;
  logic               last_beat;
  logic               push;
  logic               pop;
  logic               full;
  logic               wr_en;
  logic               q_valid;

  always_comb begin
    pair = (swap_q == SWAP_FALL_LOW) ? {r_vec, f_vec} : {f_vec, r_vec};
    word_next = asm_q;
    word_next[int'(k) * PAIR_W +: PAIR_W] = pair;
  end

  assign last_beat = (k == KW'(BEATS - 1));
  assign push      = ce_q && last_beat;
  assign q_valid   = (level_q != '0);
  assign pop       = q_valid && bus.q_ready;
  assign full      = (level_q == LEVEL_W'(DEPTH));
  // a pop on the same edge frees the slot, so a full FIFO can still accept
  assign wr_en     = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k       <= '0;
      asm_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else if (bus.clr) begin
      k       <= '0;
      asm_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (ce_q) begin
        asm_q <= word_next;
        k     <= last_beat ? '0 : k + 1'b1;
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !bus.clr) mem[wr_ptr] <= word_next;
  end

  assign bus.q        = q_valid ? mem[rd_ptr] : '0;
  assign bus.q_valid  = q_valid;
  assign bus.level    = level_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_ddr_in_gearbox.sv
// tb/tb_ddr_in_gearbox.sv - directed scoreboard bench for ddr_in_gearbox
module tb_ddr_in_gearbox;
  import ddr_in_gearbox_pkg::*;

  localparam int WIDTH  = 4;
  localparam int BEATS  = 2;
  localparam int DEPTH  = 2;
  localparam int WORD_W = 2 * WIDTH * BEATS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr_in_gearbox_if #(.WIDTH(WIDTH), .BEATS(BEATS), .DEPTH(DEPTH)) bus ();

  ddr_in_gearbox #(.WIDTH(WIDTH), .BEATS(BEATS), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [WORD_W-1:0] sb[$];
  logic exp_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called at negedge+1; returns at the next negedge+1 with ce dropped
  task automatic beat(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] f, input logic c);
    bus.d = r;
    bus.ce = c;
    @(posedge clk); #1;
    bus.d = f;
    @(negedge clk); #1;
    bus.ce = 1'b0;
    bus.d = '0;
  endtask

  task automatic settle();
    repeat (2) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic model_push(input logic [WORD_W-1:0] w);
    if (sb.size() < DEPTH) sb.push_back(w);
    else exp_ovf = 1'b1;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    for (int b = 0; b < BEATS; b++)
      beat(w[b*2*WIDTH +: WIDTH], w[b*2*WIDTH+WIDTH +: WIDTH], 1'b1);
    settle();
    model_push(w);
  endtask

  task automatic pop_check(input string tag);
    logic [WORD_W-1:0] exp;
    int n;
    n = 0;
    while (!bus.q_valid && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (!bus.q_valid) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else if (sb.size() == 0) begin
      check({tag, "_unexpected"}, {16'd0, bus.q}, 32'hdead);
    end else begin
      exp = sb.pop_front();
      check(tag, {16'd0, bus.q}, {16'd0, exp});
      bus.q_ready = 1'b1;
      @(posedge clk); #1;
      bus.q_ready = 1'b0;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    bus.d = '0;
    bus.ce = 1'b0;
    bus.clr = 1'b0;
    bus.swap = 1'b0;
    bus.q_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_q_valid", {31'd0, bus.q_valid}, 32'd0);
    check("reset_level", {30'd0, bus.level}, 32'd0);
    check("reset_overflow", {31'd0, bus.overflow}, 32'd0);
    check("reset_q", {16'd0, bus.q}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // basic word and latency
    beat(4'h1, 4'h2, 1'b1);
    beat(4'h3, 4'h4, 1'b1);
    @(posedge clk); #1;
    check("t1_valid_early", {31'd0, bus.q_valid}, 32'd0);
    @(posedge clk); #1;
    check("t1_valid_on_time", {31'd0, bus.q_valid}, 32'd1);
    check("t1_level", {30'd0, bus.level}, 32'd1);
    check("t1_q", {16'd0, bus.q}, 32'h4321);
    @(negedge clk); #1;
    sb.push_back(16'h4321);
    pop_check("t1_pop");
    check("t1_level_after_pop", {30'd0, bus.level}, 32'd0);

    // swapped pair order
    bus.swap = 1'b1;
    beat(4'h1, 4'h2, 1'b1);
    beat(4'h3, 4'h4, 1'b1);
    bus.swap = 1'b0;
    settle();
    sb.push_back(16'h3412);
    pop_check("t2_swap");

    // ce low pair is discarded
    beat(4'h1, 4'h2, 1'b1);
    beat(4'h9, 4'h9, 1'b0);
    beat(4'h3, 4'h4, 1'b1);
    settle();
    sb.push_back(16'h4321);
    pop_check("t3_ce_gap");
    check("t3_valid_after_pop", {31'd0, bus.q_valid}, 32'd0);

    // overflow with consumer stalled
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    check("t4_level_full", {30'd0, bus.level}, 32'd2);
    check("t4_overflow", {31'd0, bus.overflow}, {31'd0, exp_ovf});
    pop_check("t4_pop1");
    pop_check("t4_pop2");
    check("t4_overflow_sticky", {31'd0, bus.overflow}, 32'd1);
    bus.q_ready = 1'b1;
    @(posedge clk); #1;
    bus.q_ready = 1'b0;
    check("t4_no_underflow", {30'd0, bus.level}, 32'd0);
    @(negedge clk); #1;

    // clr mid-word with a queued word and overflow pending
    send_word(16'h1111);
    beat(4'ha, 4'hb, 1'b1);
    settle();
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    check("t5_clr_overflow", {31'd0, bus.overflow}, 32'd0);
    check("t5_clr_level", {30'd0, bus.level}, 32'd0);
    check("t5_clr_valid", {31'd0, bus.q_valid}, 32'd0);
    @(negedge clk); #1;
    beat(4'h5, 4'h6, 1'b1);
    beat(4'h7, 4'h8, 1'b1);
    settle();
    sb.push_back(16'h8765);
    pop_check("t5_after_clr");
    check("t5_overflow_end", {31'd0, bus.overflow}, 32'd0);

    // full FIFO with push and pop on the same edge
    send_word(16'h1111);
    send_word(16'h2222);
    check("t6_level_full", {30'd0, bus.level}, 32'd2);
    beat(4'h3, 4'h3, 1'b1);
    beat(4'h3, 4'h3, 1'b1);
    @(posedge clk);
    @(negedge clk); #1;
    check("t6_head", {16'd0, bus.q}, {16'd0, sb.pop_front()});
    bus.q_ready = 1'b1;
    @(posedge clk); #1;
    bus.q_ready = 1'b0;
    sb.push_back(16'h3333);
    check("t6_level_same", {30'd0, bus.level}, 32'd2);
    check("t6_overflow_clear", {31'd0, bus.overflow}, 32'd0);
    @(negedge clk); #1;
    pop_check("t6_pop2");
    pop_check("t6_pop3");

    // asynchronous reset mid-word
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    check("t7_overflow_set", {31'd0, bus.overflow}, 32'd1);
    beat(4'ha, 4'hb, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_valid", {31'd0, bus.q_valid}, 32'd0);
    check("t7_rst_level", {30'd0, bus.level}, 32'd0);
    check("t7_rst_overflow", {31'd0, bus.overflow}, 32'd0);
    check("t7_rst_q", {16'd0, bus.q}, 32'd0);
    sb.delete();
    exp_ovf = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    beat(4'h5, 4'h6, 1'b1);
    beat(4'h7, 4'h8, 1'b1);
    settle();
    sb.push_back(16'h8765);
    pop_check("t7_after_rst");
    check("t7_overflow_end", {31'd0, bus.overflow}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
